// File: rtl/ntt_pkg.sv
// ============================================================================
// Module      : ntt_pkg
// Description : Shared definitions for the parametrised NTT/INTT butterfly
//               address generator: transform modes, FSM state encoding and
//               elaboration-time sizing helpers.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package ntt_pkg;

    // Transform direction, as sampled from Sel on an accepted start
    localparam logic MODE_NTT  = 1'b0;   // Cooley-Tukey ordering
    localparam logic MODE_INTT = 1'b1;   // Gentleman-Sande ordering

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of butterfly stages between span N/2 and span 2^log_stop
    function automatic int nstage(input int log_n, input int log_stop);
        return log_n - log_stop;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    // Stage counter width; a single-stage transform still needs one bit
    function automatic int stage_w(input int ns);
        return (clog2(ns) > 0) ? clog2(ns) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_addrgen_p_if.sv
// ============================================================================
// Module      : ntt_addrgen_p_if
// Description : Beat bus between the address generator (master) and the
//               butterfly datapath / memories (slave).
//               o_valid/i_ready  : beat handshake
//               addr_up/addr_dn  : butterfly coefficient addresses
//               zeta_idx         : twiddle ROM index
//               stage_idx        : current stage, 0-based
//               last_stage       : current stage is the final one
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

interface ntt_addrgen_p_if #(
    parameter int LOG_N    = 8,
    parameter int LOG_STOP = 1
);
    localparam int SW = ntt_pkg::stage_w(ntt_pkg::nstage(LOG_N, LOG_STOP));

    logic             o_valid;
    logic             i_ready;
    logic [LOG_N-1:0] addr_up;
    logic [LOG_N-1:0] addr_dn;
    logic [LOG_N-2:0] zeta_idx;
    logic [SW-1:0]    stage_idx;
    logic             last_stage;

    modport master (
        output o_valid, addr_up, addr_dn, zeta_idx, stage_idx, last_stage,
        input  i_ready
    );

    modport slave (
        input  o_valid, addr_up, addr_dn, zeta_idx, stage_idx, last_stage,
        output i_ready
    );

endinterface

`default_nettype wire

// File: rtl/ntt_addr_map.sv
// ============================================================================
// Module      : ntt_addr_map
// Description : Combinational butterfly address map.
//               (sel, stage, beat) -> (addr_up, addr_dn, zeta_idx)
//               sel      : MODE_NTT / MODE_INTT
//               stage    : stage index s
//               beat     : beat index b within the stage, 0..N/2-1
//               addr_up  : (g << (L+1)) | o, with g = b>>L, o = b mod 2^L
//               addr_dn  : addr_up + 2^L
//               zeta_idx : twiddle ROM index
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module ntt_addr_map
    import ntt_pkg::*;
#(
    parameter int LOG_N    = 8,
    parameter int LOG_STOP = 1
) (
    input  logic                                   sel,
    input  logic [stage_w(nstage(LOG_N, LOG_STOP))-1:0] stage,
    input  logic [LOG_N-2:0]                       beat,
    output logic [LOG_N-1:0]                       addr_up,
    output logic [LOG_N-1:0]                       addr_dn,
    output logic [LOG_N-2:0]                       zeta_idx
);
    localparam int NSTAGE = nstage(LOG_N, LOG_STOP);
    localparam int ZW     = LOG_N - 1;
    localparam logic [LOG_N-1:0] c_one   = LOG_N'(1);
    localparam logic [ZW-1:0]    c_one_z = ZW'(1);

    int               w_l;        // span exponent L
    int               w_sp;       // mirrored stage index used by INTT twiddles
    logic [LOG_N-1:0] w_len;
    logic [LOG_N-1:0] w_off;
    logic [LOG_N-1:0] w_grp;
    logic [LOG_N-1:0] w_up;
    logic [ZW-1:0]    w_grp_z;

    always_comb begin
        // NTT halves the span each stage, INTT doubles it
        if (sel == MODE_NTT) begin
            w_l = LOG_N - 1 - int'(stage);
        end else begin
            w_l = LOG_STOP + int'(stage);
        end
        w_sp    = NSTAGE - 1 - int'(stage);
        w_len   = c_one << w_l;
        w_grp_z = beat >> w_l;
        w_grp   = {1'b0, w_grp_z};
        w_off   = {1'b0, beat} & (w_len - c_one);
        w_up    = (w_grp << (w_l + 1)) | w_off;

        addr_up = w_up;
        addr_dn = w_up + w_len;

        // NTT walks twiddles upward from 2^s, INTT walks them downward
        if (sel == MODE_NTT) begin
            zeta_idx = (c_one_z << stage) + w_grp_z;
        end else begin
            zeta_idx = (c_one_z << (w_sp + 1)) - c_one_z - w_grp_z;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ntt_addrgen_p.sv
// ============================================================================
// Module      : ntt_addrgen_p
// Description : Parametrised NTT/INTT butterfly address generator with
//               valid/ready backpressure and a programmable inter-stage gap.
//               clk, rst_n : clock / asynchronous active-low reset
//               i_start    : start request, honoured only when idle
//               Sel        : 0 NTT, 1 INTT, sampled with an accepted start
//               bus        : beat bus (master side), see ntt_addrgen_p_if
//               active     : run in progress (RUN or GAP)
//               done       : one-cycle pulse after the last beat is accepted
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module ntt_addrgen_p
    import ntt_pkg::*;
#(
    parameter int LOG_N     = 8,
    parameter int LOG_STOP  = 1,
    parameter int STAGE_GAP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             Sel,
    ntt_addrgen_p_if.master  bus,
    output logic             active,
    output logic             done
);
    localparam int NSTAGE = nstage(LOG_N, LOG_STOP);
    localparam int SW     = stage_w(NSTAGE);
    localparam int BW     = LOG_N - 1;

    localparam logic [SW-1:0] c_last_stage = SW'(NSTAGE - 1);
    localparam logic [BW-1:0] c_last_beat  = '1;            // N/2 - 1
    localparam logic [3:0]    c_gap_load   = (STAGE_GAP > 0) ? 4'(STAGE_GAP - 1) : 4'd0;

    state_t           r_state, w_state_nxt;
    logic             r_sel, w_sel_nxt;
    logic [SW-1:0]    r_stage, w_stage_nxt;
    logic [BW-1:0]    r_beat, w_beat_nxt;
    logic [3:0]       r_gap, w_gap_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_active, w_active_nxt;
    logic             r_done, w_done_nxt;
    logic             r_last;
    logic [LOG_N-1:0] r_up, r_dn, w_up, w_dn;
    logic [BW-1:0]    r_zeta, w_zeta;
    logic             w_accept;

    assign w_accept = r_valid & bus.i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_stage_nxt  = r_stage;
        w_beat_nxt   = r_beat;
        w_gap_nxt    = r_gap;
        w_valid_nxt  = r_valid;
        w_active_nxt = r_active;
        w_done_nxt   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt  = ST_RUN;
                    w_sel_nxt    = Sel;
                    w_stage_nxt  = '0;
                    w_beat_nxt   = '0;
                    w_valid_nxt  = 1'b1;
                    w_active_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                // Without acceptance every counter, and so every output, holds
                if (w_accept) begin
                    if (r_beat == c_last_beat) begin
                        if (r_stage == c_last_stage) begin
                            w_state_nxt  = ST_DONE;
                            w_valid_nxt  = 1'b0;
                            w_active_nxt = 1'b0;
                            w_done_nxt   = 1'b1;
                        end else begin
                            w_stage_nxt = r_stage + SW'(1);
                            w_beat_nxt  = '0;
                            if (STAGE_GAP > 0) begin
                                w_state_nxt = ST_GAP;
                                w_valid_nxt = 1'b0;
                                w_gap_nxt   = c_gap_load;
                            end
                        end
                    end else begin
                        w_beat_nxt = r_beat + BW'(1);
                    end
                end
            end
            ST_GAP: begin
                // Loaded with STAGE_GAP-1, so the gap lasts STAGE_GAP cycles
                if (r_gap == 4'd0) begin
                    w_state_nxt = ST_RUN;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_gap_nxt = r_gap - 4'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Map the upcoming beat so the addresses land in registers with o_valid
    ntt_addr_map #(
        .LOG_N    (LOG_N),
        .LOG_STOP (LOG_STOP)
    ) u_map (
        .sel      (w_sel_nxt),
        .stage    (w_stage_nxt),
        .beat     (w_beat_nxt),
        .addr_up  (w_up),
        .addr_dn  (w_dn),
        .zeta_idx (w_zeta)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= 1'b0;
            r_stage  <= '0;
            r_beat   <= '0;
            r_gap    <= 4'd0;
            r_valid  <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_last   <= 1'b0;
            r_up     <= '0;
            r_dn     <= '0;
            r_zeta   <= '0;
        end else begin
            r_sel    <= w_sel_nxt;
            r_stage  <= w_stage_nxt;
            r_beat   <= w_beat_nxt;
            r_gap    <= w_gap_nxt;
            r_valid  <= w_valid_nxt;
            r_active <= w_active_nxt;
            r_done   <= w_done_nxt;
            if (w_valid_nxt) begin
                r_up   <= w_up;
                r_dn   <= w_dn;
                r_zeta <= w_zeta;
                r_last <= (w_stage_nxt == c_last_stage);
            end
        end
    end

    assign bus.o_valid    = r_valid;
    assign bus.addr_up    = r_up;
    assign bus.addr_dn    = r_dn;
    assign bus.zeta_idx   = r_zeta;
    assign bus.stage_idx  = r_stage;
    assign bus.last_stage = r_last;
    assign active         = r_active;
    assign done           = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ntt_addrgen_p.sv
// ============================================================================
// Module      : tb_ntt_addrgen_p
// Description : Scoreboard bench for ntt_addrgen_p. Three instances:
//               0: defaults, 1: STAGE_GAP=3, 2: LOG_N=4.
//               Expected beats come from a loop-nest reference of the
//               NTT/INTT butterfly schedule and are checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ntt_addrgen_p;

    typedef struct {
        int up;
        int dn;
        int zeta;
        int stage;
        int last;
    } beat_t;
    typedef beat_t beat_q_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int   c_ln[3] = '{8, 8, 4};
    int   c_ls[3] = '{1, 1, 1};
    logic st[3]   = '{1'b0, 1'b0, 1'b0};
    logic sl[3]   = '{1'b0, 1'b0, 1'b0};
    logic rdy[3]  = '{1'b1, 1'b1, 1'b1};
    logic vld[3];
    logic dn_w[3];
    logic act[3];

    beat_q_t q[3];
    bit      hold[3];
    beat_t   prev[3];
    int      dones[3] = '{0, 0, 0};
    int      b_gap_run = 0;
    int      b_bnd     = 0;

    // ------------------------------------------------------------------ DUTs
    ntt_addrgen_p_if #(.LOG_N(8), .LOG_STOP(1)) a_if ();
    ntt_addrgen_p_if #(.LOG_N(8), .LOG_STOP(1)) b_if ();
    ntt_addrgen_p_if #(.LOG_N(4), .LOG_STOP(1)) c_if ();
    logic a_active, a_done, b_active, b_done, c_active, c_done;

    ntt_addrgen_p #(.LOG_N(8), .LOG_STOP(1), .STAGE_GAP(0)) u_a (
        .clk(clk), .rst_n(rst_n), .i_start(st[0]), .Sel(sl[0]),
        .bus(a_if), .active(a_active), .done(a_done));
    ntt_addrgen_p #(.LOG_N(8), .LOG_STOP(1), .STAGE_GAP(3)) u_b (
        .clk(clk), .rst_n(rst_n), .i_start(st[1]), .Sel(sl[1]),
        .bus(b_if), .active(b_active), .done(b_done));
    ntt_addrgen_p #(.LOG_N(4), .LOG_STOP(1), .STAGE_GAP(0)) u_c (
        .clk(clk), .rst_n(rst_n), .i_start(st[2]), .Sel(sl[2]),
        .bus(c_if), .active(c_active), .done(c_done));

    assign a_if.i_ready = rdy[0];
    assign b_if.i_ready = rdy[1];
    assign c_if.i_ready = rdy[2];
    assign vld[0] = a_if.o_valid;  assign dn_w[0] = a_done;  assign act[0] = a_active;
    assign vld[1] = b_if.o_valid;  assign dn_w[1] = b_done;  assign act[1] = b_active;
    assign vld[2] = c_if.o_valid;  assign dn_w[2] = c_done;  assign act[2] = c_active;

    // ------------------------------------------------------ reference model
    // Textbook loop nests: NTT spans N/2 down to 2^LOG_STOP with the twiddle
    // counter climbing from 1; INTT spans upward with it falling from 2^NS-1.
    function automatic beat_q_t gen(input int log_n, input int log_stop, input bit sel);
        beat_q_t r;
        beat_t   e;
        int n, ns, k, s;
        n  = 1 << log_n;
        ns = log_n - log_stop;
        s  = 0;
        if (!sel) begin
            k = 1;
            for (int len = n / 2; len >= (1 << log_stop); len = len / 2) begin
                for (int b0 = 0; b0 < n; b0 += 2 * len) begin
                    for (int j = b0; j < b0 + len; j++) begin
                        e.up = j; e.dn = j + len; e.zeta = k; e.stage = s;
                        e.last = (s == ns - 1) ? 1 : 0;
                        r.push_back(e);
                    end
                    k++;
                end
                s++;
            end
        end else begin
            k = (1 << ns) - 1;
            for (int len = 1 << log_stop; len <= n / 2; len = len * 2) begin
                for (int b0 = 0; b0 < n; b0 += 2 * len) begin
                    for (int j = b0; j < b0 + len; j++) begin
                        e.up = j; e.dn = j + len; e.zeta = k; e.stage = s;
                        e.last = (s == ns - 1) ? 1 : 0;
                        r.push_back(e);
                    end
                    k--;
                end
                s++;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------- helpers
    function automatic void chk(input string name, input bit ok, input string got, input string exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic string fmt(input beat_t x);
        return $sformatf("%0d/%0d z%0d s%0d l%0d", x.up, x.dn, x.zeta, x.stage, x.last);
    endfunction

    function automatic bit same(input beat_t x, input beat_t y);
        return (x.up == y.up) && (x.dn == y.dn) && (x.zeta == y.zeta) &&
               (x.stage == y.stage) && (x.last == y.last);
    endfunction

    function automatic beat_t mk(input int up, input int dn, input int z, input int s, input int l);
        beat_t e;
        e.up = up; e.dn = dn; e.zeta = z; e.stage = s; e.last = l;
        return e;
    endfunction

    task automatic mon_step(input int id, input bit v, input bit r, input bit d, input beat_t cur);
        beat_t e;
        if (hold[id])
            chk($sformatf("stall_hold_%0d", id), v && same(cur, prev[id]),
                $sformatf("v%0d %s", v, fmt(cur)), $sformatf("v1 %s", fmt(prev[id])));
        if (v && r) begin
            if (q[id].size() == 0) begin
                chk($sformatf("extra_beat_%0d", id), 1'b0, fmt(cur), "no beat");
            end else begin
                e = q[id].pop_front();
                chk($sformatf("beat_%0d", id), same(e, cur), fmt(cur), fmt(e));
            end
        end
        hold[id] = v && !r;
        prev[id] = cur;
        if (d) begin
            chk($sformatf("done_after_last_%0d", id), q[id].size() == 0,
                $sformatf("%0d beats left", q[id].size()), "0 beats left");
            dones[id]++;
        end
    endtask

    // -------------------------------------------------------------- monitor
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) hold[i] = 1'b0;
            b_gap_run = 0;
        end else begin
            mon_step(0, a_if.o_valid, a_if.i_ready, a_done,
                     mk(int'(a_if.addr_up), int'(a_if.addr_dn), int'(a_if.zeta_idx),
                        int'(a_if.stage_idx), int'(a_if.last_stage)));
            mon_step(1, b_if.o_valid, b_if.i_ready, b_done,
                     mk(int'(b_if.addr_up), int'(b_if.addr_dn), int'(b_if.zeta_idx),
                        int'(b_if.stage_idx), int'(b_if.last_stage)));
            mon_step(2, c_if.o_valid, c_if.i_ready, c_done,
                     mk(int'(c_if.addr_up), int'(c_if.addr_dn), int'(c_if.zeta_idx),
                        int'(c_if.stage_idx), int'(c_if.last_stage)));
            if (b_active && !b_if.o_valid) begin
                b_gap_run++;
            end else if (b_if.o_valid && b_gap_run > 0) begin
                chk("b_gap_len", b_gap_run == 3, $sformatf("%0d", b_gap_run), "3");
                b_bnd++;
                b_gap_run = 0;
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    // mode 0: ready always 1; 1: random ready plus stray start/Sel toggles;
    // 2: ready dropped for 5 cycles while stage-0 beat 10 is presented.
    task automatic run(input int id, input bit sel, input int mode, input int exp_cyc);
        int cyc, held;
        bit got_done;
        cyc = 0; held = 0; got_done = 1'b0;
        q[id] = gen(c_ln[id], c_ls[id], sel);
        st[id] = 1'b1; sl[id] = sel; rdy[id] = 1'b1;
        @(posedge clk); #1;
        st[id] = 1'b0;
        while (!got_done && cyc < 5000) begin
            case (mode)
                1: begin
                    rdy[id] = ($urandom_range(0, 3) != 0);
                    st[id]  = ($urandom_range(0, 15) == 0);
                    sl[id]  = 1'($urandom_range(0, 1));
                end
                2: begin
                    if (a_if.o_valid && a_if.addr_up == 8'd10 && a_if.stage_idx == 3'd0 && held < 5) begin
                        rdy[id] = 1'b0;
                        held++;
                    end else begin
                        rdy[id] = 1'b1;
                    end
                end
                default: rdy[id] = 1'b1;
            endcase
            @(posedge clk); #1;
            cyc++;
            got_done = dn_w[id];
        end
        chk($sformatf("done_seen_%0d", id), got_done, $sformatf("%0d", got_done), "1");
        if (exp_cyc > 0)
            chk($sformatf("done_cycle_%0d", id), cyc == exp_cyc, $sformatf("%0d", cyc), $sformatf("%0d", exp_cyc));
        chk($sformatf("done_inactive_%0d", id), !act[id] && !vld[id],
            $sformatf("active%0d valid%0d", act[id], vld[id]), "active0 valid0");
        // Start held through the DONE cycle must not launch a new run
        st[id] = 1'b1;
        @(posedge clk); #1;
        st[id] = 1'b0; rdy[id] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("start_in_done_ignored_%0d", id), !vld[id] && !act[id],
            $sformatf("valid%0d active%0d", vld[id], act[id]), "valid0 active0");
        q[id].delete();
    endtask

    initial begin
        int d0;
        #2;
        chk("reset_a", !a_if.o_valid && a_if.addr_up == 0 && a_if.addr_dn == 0 && a_if.zeta_idx == 0 &&
            a_if.stage_idx == 0 && !a_if.last_stage && !a_active && !a_done,
            $sformatf("v%0d %0d/%0d z%0d", a_if.o_valid, a_if.addr_up, a_if.addr_dn, a_if.zeta_idx), "all 0");
        chk("reset_b", !b_if.o_valid && b_if.addr_dn == 0 && !b_active && !b_done,
            $sformatf("v%0d dn%0d", b_if.o_valid, b_if.addr_dn), "all 0");
        chk("reset_c", !c_if.o_valid && c_if.addr_dn == 0 && !c_active && !c_done,
            $sformatf("v%0d dn%0d", c_if.o_valid, c_if.addr_dn), "all 0");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 1'b0, 0, 896);
        run(0, 1'b1, 0, 896);
        run(0, 1'b0, 2, 901);
        run(0, 1'b1, 1, 0);
        run(0, 1'b0, 1, 0);

        b_bnd = 0;
        run(1, 1'b0, 0, 914);
        chk("b_boundaries_ntt", b_bnd == 6, $sformatf("%0d", b_bnd), "6");
        b_bnd = 0;
        run(1, 1'b1, 1, 0);
        chk("b_boundaries_intt", b_bnd == 6, $sformatf("%0d", b_bnd), "6");

        run(2, 1'b0, 0, 24);
        run(2, 1'b1, 1, 0);

        // Asynchronous reset in the middle of a run, with start also high
        q[0] = gen(8, 1, 1'b0);
        st[0] = 1'b1; sl[0] = 1'b0; rdy[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        d0 = dones[0];
        rst_n = 1'b0;
        st[0] = 1'b1;
        #1;
        chk("rst_async_zero", !a_if.o_valid && a_if.addr_up == 0 && a_if.addr_dn == 0 &&
            a_if.zeta_idx == 0 && a_if.stage_idx == 0 && !a_if.last_stage && !a_active && !a_done,
            $sformatf("v%0d %0d/%0d z%0d s%0d act%0d", a_if.o_valid, a_if.addr_up, a_if.addr_dn,
                      a_if.zeta_idx, a_if.stage_idx, a_active), "all 0");
        q[0].delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        st[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_done_no_start", dones[0] == d0 && !a_if.o_valid && !a_active,
            $sformatf("dones+%0d v%0d act%0d", dones[0] - d0, a_if.o_valid, a_active), "dones+0 v0 act0");
        run(0, 1'b0, 0, 896);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
